// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Gated frequency meter on the F10M domain. Counts rising edges of
//            an asynchronous signal over a window of GATE_CYCLES clocks and
//            publishes the (saturating) count at the end of every window.
//            Optional sequential binary-to-BCD converter behind the macro
//            FMETER_BCD_EN.
// Ports    : F10M      - system clock, all logic on rising edge
//            RESET     - synchronous, active-low reset
//            EN        - measurement enable (level)
//            SIG       - asynchronous signal under test
//            FREQ      - edge count of the last completed window
//            OVF       - last completed window saturated FREQ
//            VALID     - one-cycle pulse, FREQ/OVF updated
//            FREQ_BCD  - BCD of FREQ (FMETER_BCD_EN only, else 0)
//            BCD_VALID - one-cycle pulse, FREQ_BCD updated (FMETER_BCD_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter #(
  parameter int GATE_CYCLES = 10000000,
  parameter int CNT_W       = 24,
  parameter int DIGITS      = 8
) (
  input  logic                  F10M,
  input  logic                  RESET,
  input  logic                  EN,
  input  logic                  SIG,
  output logic [CNT_W-1:0]      FREQ,
  output logic                  OVF,
  output logic                  VALID,
  output logic [4*DIGITS-1:0]   FREQ_BCD,
  output logic                  BCD_VALID
);

  localparam int                c_gate_w    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [c_gate_w-1:0] c_gate_last = c_gate_w'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_cnt_max   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_GATE = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronizer plus edge register
  // --------------------------------------------------------------------------
  logic sync1_q, sync2_q, sync3_q;
  logic w_rise;

  always_ff @(posedge F10M) begin
    if (!RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= SIG;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign w_rise = sync2_q & ~sync3_q;

  // --------------------------------------------------------------------------
  // Gate FSM and counters
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [c_gate_w-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic                sat_q, sat_d;
  logic [CNT_W-1:0]    freq_q, freq_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;

  // Edge count and overflow flag including the current cycle's rise; the
  // counter sticks at its maximum and the flag records the lost edge.
  logic [CNT_W-1:0]    w_edge_inc;
  logic                w_sat_inc;

  always_comb begin
    w_edge_inc = edge_cnt_q;
    w_sat_inc  = sat_q;
    if (w_rise) begin
      if (edge_cnt_q == c_cnt_max) begin
        w_sat_inc = 1'b1;
      end else begin
        w_edge_inc = edge_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge F10M) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        if (EN) begin
          state_d = S_GATE;
        end
      end

      S_GATE: begin
        if (gate_cnt_q == c_gate_last) begin
          // Window completes even if EN just dropped; the rise of this
          // cycle still belongs to the ending window.
          freq_d     = w_edge_inc;
          ovf_d      = w_sat_inc;
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = EN ? S_GATE : S_IDLE;
        end else if (!EN) begin
          // Aborted window: partial count discarded, outputs untouched.
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          state_d    = S_IDLE;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          edge_cnt_d = w_edge_inc;
          sat_d      = w_sat_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign FREQ  = freq_q;
  assign OVF   = ovf_q;
  assign VALID = valid_q;

`ifdef FMETER_BCD_EN
  // --------------------------------------------------------------------------
  // Sequential double-dabble converter. The first step runs in the VALID
  // cycle itself, reading FREQ directly, so the result lands CNT_W cycles
  // after VALID. Digits above DIGITS simply shift out of the accumulator.
  // --------------------------------------------------------------------------
  localparam int c_bcd_w  = 4 * DIGITS;
  localparam int c_left_w = $clog2(CNT_W + 1);

  logic [c_bcd_w-1:0]  bcd_acc_q, bcd_acc_d;
  logic [CNT_W-1:0]    bcd_sh_q, bcd_sh_d;
  logic [c_left_w-1:0] bcd_left_q, bcd_left_d;
  logic                bcd_busy_q, bcd_busy_d;
  logic [c_bcd_w-1:0]  freq_bcd_q, freq_bcd_d;
  logic                bcd_valid_q, bcd_valid_d;

  logic [c_bcd_w-1:0]  w_src_acc;
  logic [CNT_W-1:0]    w_src_sh;
  logic [c_left_w-1:0] w_src_left;
  logic [c_bcd_w-1:0]  w_adj_acc;
  logic [c_bcd_w-1:0]  w_step_acc;
  logic [c_left_w-1:0] w_step_left;

  function automatic logic [c_bcd_w-1:0] add3(input logic [c_bcd_w-1:0] v);
    logic [c_bcd_w-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // A VALID always restarts from FREQ, dropping any conversion in flight.
  assign w_src_acc   = valid_q ? '0 : bcd_acc_q;
  assign w_src_sh    = valid_q ? freq_q : bcd_sh_q;
  assign w_src_left  = valid_q ? c_left_w'(CNT_W) : bcd_left_q;
  assign w_adj_acc   = add3(w_src_acc);
  assign w_step_acc  = (w_adj_acc << 1) | {{(c_bcd_w-1){1'b0}}, w_src_sh[CNT_W-1]};
  assign w_step_left = w_src_left - 1'b1;

  always_comb begin
    bcd_acc_d   = bcd_acc_q;
    bcd_sh_d    = bcd_sh_q;
    bcd_left_d  = bcd_left_q;
    bcd_busy_d  = bcd_busy_q;
    freq_bcd_d  = freq_bcd_q;
    bcd_valid_d = 1'b0;
    if (valid_q || bcd_busy_q) begin
      bcd_acc_d  = w_step_acc;
      bcd_sh_d   = w_src_sh << 1;
      bcd_left_d = w_step_left;
      if (w_step_left == '0) begin
        bcd_busy_d  = 1'b0;
        freq_bcd_d  = w_step_acc;
        bcd_valid_d = 1'b1;
      end else begin
        bcd_busy_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge F10M) begin
    if (!RESET) begin
      bcd_acc_q   <= '0;
      bcd_sh_q    <= '0;
      bcd_left_q  <= '0;
      bcd_busy_q  <= 1'b0;
      freq_bcd_q  <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      bcd_acc_q   <= bcd_acc_d;
      bcd_sh_q    <= bcd_sh_d;
      bcd_left_q  <= bcd_left_d;
      bcd_busy_q  <= bcd_busy_d;
      freq_bcd_q  <= freq_bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign FREQ_BCD  = freq_bcd_q;
  assign BCD_VALID = bcd_valid_q;
`else
  assign FREQ_BCD  = '0;
  assign BCD_VALID = 1'b0;
`endif

endmodule
`default_nettype wire
